// File: rtl/trig_level_ctrl_if.sv
// Front-panel key / trigger-level bundle for trig_level_ctrl.
// master drives the raw keys, slave produces the trigger level.
interface trig_level_ctrl_if;
  logic        button_u;
  logic        button_d;
  logic [11:0] TRIG;
  logic        trig_step;

  modport master (
    output button_u,
    output button_d,
    input  TRIG,
    input  trig_step
  );

  modport slave (
    input  button_u,
    input  button_d,
    output TRIG,
    output trig_step
  );
endinterface

// File: rtl/trig_level_ctrl.sv
// Trigger-level controller: key sync/debounce, saturating step, recentre.
// Auto-repeat (HOLD/REPEAT states, hold counter) built only with TRIG_AUTOREPEAT_EN.
module trig_level_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 1_000_000,
  parameter int          REPEAT_DELAY    = 25_000_000,
  parameter int          REPEAT_RATE     = 5_000_000,
  parameter int          STEP            = 16,
  parameter logic [11:0] TRIG_INIT       = 12'd2048
) (
  input  logic              CLK,
  input  logic              RSTB,
  trig_level_ctrl_if.slave  bus
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [12:0] STEP13 = 13'(STEP);

  if (DEBOUNCE_CYCLES < 1 || STEP < 1 || STEP > 4095 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    $error("trig_level_ctrl: parameter out of range");
  end

`ifdef TRIG_AUTOREPEAT_EN
  localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int HCW  = $clog2(HMAX + 1);
  // Loaded one short: the step fires on the cycle the count is seen at 0.
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(REPEAT_DELAY - 1);
  localparam logic [HCW-1:0] RATE_LOAD = HCW'(REPEAT_RATE - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_BOTH
`ifdef TRIG_AUTOREPEAT_EN
    ,
    S_HOLD,
    S_REPEAT
`endif
  } state_t;

  // Bit 0 = up key, bit 1 = down key; raw polarity (0 = pressed).
  logic [1:0]     r_s1;
  logic [1:0]     r_s2;
  logic [1:0]     r_db;
  logic [DBW-1:0] r_dcnt [2];

  logic w_up_p;
  logic w_dn_p;
  logic w_act;
  logic w_oth;

  state_t      r_state;
  state_t      w_nstate;
  logic        r_dir;
  logic        w_ndir;
  logic        w_step;
  logic        w_init;
  logic [11:0] r_trig;
  logic        r_step;
  logic [11:0] w_trig_nxt;
  logic [12:0] w_sum;
  logic [12:0] w_dif;
  logic [11:0] w_up_v;
  logic [11:0] w_dn_v;

`ifdef TRIG_AUTOREPEAT_EN
  logic [HCW-1:0] r_hcnt;
  logic [HCW-1:0] w_hcnt;
`endif

  // Two-flop synchronisers, idle-high so reset reads as released.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_s1 <= 2'b11;
      r_s2 <= 2'b11;
    end else begin
      r_s1 <= {bus.button_d, bus.button_u};
      r_s2 <= r_s1;
    end
  end

  // Per-key debouncer: flip after DEBOUNCE_CYCLES mismatched cycles.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_db      <= 2'b11;
      r_dcnt[0] <= '0;
      r_dcnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_db[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DB_LAST) begin
          r_db[i]   <= r_s2[i];
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + DBW'(1);
        end
      end
    end
  end

  assign w_up_p = ~r_db[0];
  assign w_dn_p = ~r_db[1];
  assign w_act  = r_dir ? w_up_p : w_dn_p;
  assign w_oth  = r_dir ? w_dn_p : w_up_p;

  // Next state, step/recentre requests and hold-counter update.
  always_comb begin
    w_nstate = r_state;
    w_ndir   = r_dir;
    w_step   = 1'b0;
    w_init   = 1'b0;
`ifdef TRIG_AUTOREPEAT_EN
    w_hcnt   = r_hcnt;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_up_p && w_dn_p) begin
          w_nstate = S_BOTH;
          w_init   = 1'b1;
        end else if (w_up_p ^ w_dn_p) begin
          w_nstate = S_FIRST;
          w_ndir   = w_up_p;
          w_step   = 1'b1;
        end
      end
      S_FIRST: begin
        if (!w_act) begin
          w_nstate = S_IDLE;
        end else if (w_oth) begin
          w_nstate = S_BOTH;
          w_init   = 1'b1;
        end else begin
`ifdef TRIG_AUTOREPEAT_EN
          w_nstate = S_HOLD;
          w_hcnt   = HOLD_LOAD;
`else
          w_nstate = S_FIRST;
`endif
        end
      end
`ifdef TRIG_AUTOREPEAT_EN
      S_HOLD, S_REPEAT: begin
        if (!w_act) begin
          w_nstate = S_IDLE;
        end else if (w_oth) begin
          w_nstate = S_BOTH;
          w_init   = 1'b1;
        end else if (r_hcnt == '0) begin
          w_nstate = S_REPEAT;
          w_step   = 1'b1;
          w_hcnt   = RATE_LOAD;
        end else begin
          w_hcnt   = r_hcnt - HCW'(1);
        end
      end
`endif
      S_BOTH: begin
        if (!w_up_p && !w_dn_p) begin
          w_nstate = S_IDLE;
        end
      end
      default: begin
        w_nstate = S_IDLE;
      end
    endcase
  end

  // Saturating step values, computed one bit wider than the level.
  always_comb begin
    w_sum  = {1'b0, r_trig} + STEP13;
    w_dif  = {1'b0, r_trig} - STEP13;
    w_up_v = w_sum[12] ? 12'hFFF : w_sum[11:0];
    w_dn_v = w_dif[12] ? 12'h000 : w_dif[11:0];
  end

  // Select the next trigger level.
  always_comb begin
    w_trig_nxt = r_trig;
    unique case (1'b1)
      w_init:            w_trig_nxt = TRIG_INIT;
      w_step &&  w_ndir: w_trig_nxt = w_up_v;
      w_step && !w_ndir: w_trig_nxt = w_dn_v;
      default:           w_trig_nxt = r_trig;
    endcase
  end

  // FSM state, direction and registered outputs.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_trig  <= TRIG_INIT;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_dir   <= w_ndir;
      r_trig  <= w_trig_nxt;
      r_step  <= (w_trig_nxt != r_trig);
    end
  end

`ifdef TRIG_AUTOREPEAT_EN
  // Hold / repeat interval counter.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_hcnt <= '0;
    end else begin
      r_hcnt <= w_hcnt;
    end
  end
`endif

  assign bus.TRIG      = r_trig;
  assign bus.trig_step = r_step;

endmodule
